dual_port_ram_ctrl: RTL

Parametrised true dual-port synchronous RAM; next generation of the team's 16-bit dual_port_ram. Adds a per-port enable and byte-enable, a configurable read mode, an optional output pipeline register with read-valid flags, and deterministic write/write collision arbitration with a flag and a saturating counter. It is the shared scratch/buffer memory between two independent masters on one clock.

---
 rtl/dual_port_ram_pkg.sv | 24 ++
 rtl/dual_port_ram_ctrl_if.sv | 27 ++
 rtl/dpr_out_pipe.sv | 41 ++++
 rtl/dual_port_ram_ctrl.sv | 95 +++++++++
 4 files changed

// File: rtl/dual_port_ram_pkg.sv
// Shared constants and the byte-merge helper for the dual-port RAM controller.
// The merge works on the widest supported word; callers size-cast in and out.
package dual_port_ram_pkg;

    localparam int WRITE_FIRST = 0;
    localparam int READ_FIRST  = 1;
    localparam int PORT1       = 1;
    localparam int PORT2       = 2;
    localparam int MAX_DATA_W  = 256;
    localparam int MAX_BE_W    = MAX_DATA_W / 8;

    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        for (int i = 0; i < MAX_BE_W; i++) begin
            merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dual_port_ram_ctrl_if.sv
// Two-master bus for the dual-port RAM: per-port request/data plus collision status.
interface dual_port_ram_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
);
    logic                en1, we1, en2, we2;
    logic [DATA_W/8-1:0] be1, be2;
    logic [ADDR_W-1:0]   addr1, addr2;
    logic [DATA_W-1:0]   data1, data2;
    logic [DATA_W-1:0]   out1, out2;
    logic                valid1, valid2;
    logic                coll;
    logic [CNT_W-1:0]    coll_cnt;

    modport master (
        output en1, we1, be1, addr1, data1,
        output en2, we2, be2, addr2, data2,
        input  out1, valid1, out2, valid2, coll, coll_cnt
    );

    modport slave (
        input  en1, we1, be1, addr1, data1,
        input  en2, we2, be2, addr2, data2,
        output out1, valid1, out2, valid2, coll, coll_cnt
    );
endinterface

// File: rtl/dpr_out_pipe.sv
// Per-port read output stage: passes data/valid straight through or adds one
// register; data holds its last value while no valid access arrives.
module dpr_out_pipe #(
    parameter int DATA_W  = 16,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data
);

    generate
        if (OUT_REG != 0) begin : g_reg
            logic              r_vld_p1;
            logic [DATA_W-1:0] r_data_p1;

            // p0 -> p1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld_p1  <= 1'b0;
                    r_data_p1 <= '0;
                end else begin
                    r_vld_p1 <= i_vld;
                    if (i_vld) r_data_p1 <= i_data;
                end
            end

            assign o_vld  = r_vld_p1;
            assign o_data = r_data_p1;
        end else begin : g_pass
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign o_vld    = i_vld;
            assign o_data   = i_data;
        end
    endgenerate

endmodule

// File: rtl/dual_port_ram_ctrl.sv
// True dual-port RAM with byte enables, selectable read mode, optional output
// register and prioritised same-address write/write collision handling.
module dual_port_ram_ctrl
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int READ_MODE = 0,
    parameter int OUT_REG   = 0,
    parameter int PRIO_PORT = 1,
    parameter int CNT_W     = 8
) (
    input logic                 clk,
    input logic                 rst,
    dual_port_ram_ctrl_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    generate
        if ((DATA_W % 8) != 0 || DATA_W > MAX_DATA_W ||
            (PRIO_PORT != PORT1 && PRIO_PORT != PORT2) ||
            (READ_MODE != WRITE_FIRST && READ_MODE != READ_FIRST)) begin : g_bad_cfg
            $fatal(1, "dual_port_ram_ctrl: illegal DATA_W/PRIO_PORT/READ_MODE");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] w_old1, w_old2, w_new1, w_new2, w_commit, w_rd1, w_rd2;
    logic              w_coll, w_wr1, w_wr2;

    assign w_old1 = r_mem[bus.addr1];
    assign w_old2 = r_mem[bus.addr2];
    assign w_new1 = DATA_W'(byte_merge(MAX_DATA_W'(w_old1), MAX_DATA_W'(bus.data1),
                                       MAX_BE_W'(bus.be1)));
    assign w_new2 = DATA_W'(byte_merge(MAX_DATA_W'(w_old2), MAX_DATA_W'(bus.data2),
                                       MAX_BE_W'(bus.be2)));

    // On a collision only the priority port's merged word reaches memory.
    assign w_coll   = bus.en1 & bus.we1 & bus.en2 & bus.we2 & (bus.addr1 == bus.addr2);
    assign w_wr1    = bus.en1 & bus.we1 & (~w_coll | (PRIO_PORT == PORT1));
    assign w_wr2    = bus.en2 & bus.we2 & (~w_coll | (PRIO_PORT == PORT2));
    assign w_commit = (PRIO_PORT == PORT1) ? w_new1 : w_new2;

    // A reader that is not itself writing always sees the pre-edge word.
    assign w_rd1 = (READ_MODE == WRITE_FIRST && bus.we1) ? (w_coll ? w_commit : w_new1) : w_old1;
    assign w_rd2 = (READ_MODE == WRITE_FIRST && bus.we2) ? (w_coll ? w_commit : w_new2) : w_old2;

    always_ff @(posedge clk) begin
        if (w_wr1) r_mem[bus.addr1] <= w_new1;
        if (w_wr2) r_mem[bus.addr2] <= w_new2;
    end

    logic              r_vld1_p0, r_vld2_p0, r_coll;
    logic [DATA_W-1:0] r_rd1_p0, r_rd2_p0;
    logic [CNT_W-1:0]  r_cnt;

    // request -> p0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld1_p0 <= 1'b0;
            r_vld2_p0 <= 1'b0;
            r_rd1_p0  <= '0;
            r_rd2_p0  <= '0;
            r_coll    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_vld1_p0 <= bus.en1;
            r_vld2_p0 <= bus.en2;
            if (bus.en1) r_rd1_p0 <= w_rd1;
            if (bus.en2) r_rd2_p0 <= w_rd2;
            r_coll <= w_coll;
            if (w_coll) r_cnt <= sat_inc(r_cnt);
        end
    end

    assign bus.coll     = r_coll;
    assign bus.coll_cnt = r_cnt;

    dpr_out_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe1 (
        .clk(clk), .rst(rst), .i_vld(r_vld1_p0), .i_data(r_rd1_p0),
        .o_vld(bus.valid1), .o_data(bus.out1)
    );

    dpr_out_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe2 (
        .clk(clk), .rst(rst), .i_vld(r_vld2_p0), .i_data(r_rd2_p0),
        .o_vld(bus.valid2), .o_data(bus.out2)
    );

endmodule
